// File: rtl/gw_video_pkg.sv
// gw_video_pkg: shared video-fetch defaults, line sizing helper and prefetch FSM states
package gw_video_pkg;
  localparam int unsigned DEF_LINE_PIXELS = 720;
  localparam int unsigned DEF_LINE_COUNT = 720;
  localparam int unsigned DEF_BYTES_PER_PIXEL = 3;
  typedef enum logic [1:0] {IDLE, REQ, BURST, GAP} prefetch_state_t;
  function automatic int unsigned words_per_line(int unsigned pixels, int unsigned bpp);
    return pixels * bpp;
  endfunction
endpackage

// File: rtl/sdram_line_prefetcher_if.sv
// sdram_line_prefetcher_if: read port between the line prefetcher and the SDRAM burst controller
interface sdram_line_prefetcher_if #(
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic rd_req, end_burst_req, data_available;
  logic [DATA_WIDTH-1:0] q;
  modport master (output addr, rd_req, end_burst_req, input data_available, q);
  modport slave (input addr, rd_req, end_burst_req, output data_available, q);
endinterface

// File: rtl/pixel_lane_packer.sv
// pixel_lane_packer: assembles one channel's pixel from successive lane bytes, first byte in the LSB
module pixel_lane_packer #(
  parameter int unsigned BYTES_PER_PIXEL = 3
) (
  input  logic clk_sys_131_072,
  input  logic reset,
  input  logic [7:0] lane_byte,
  input  logic shift_en,
  input  logic clear,
  output logic [BYTES_PER_PIXEL*8-1:0] pixel,
  output logic last
);
  localparam int unsigned CW = $clog2(BYTES_PER_PIXEL + 1);
  logic [CW-1:0] cnt;
  logic [BYTES_PER_PIXEL*8-1:0] shifted;
  assign last = shift_en && cnt == CW'(BYTES_PER_PIXEL - 1);
  if (BYTES_PER_PIXEL > 1) begin : g_shift
    assign shifted = {lane_byte, pixel[BYTES_PER_PIXEL*8-1:8]};
  end else begin : g_byte
    assign shifted = lane_byte;
  end
  always_ff @(posedge clk_sys_131_072)
    if (reset || clear) begin
      cnt <= '0;
      pixel <= '0;
    end else if (shift_en) begin
      cnt <= last ? '0 : cnt + 1'b1;
      pixel <= shifted;
    end
endmodule

// File: rtl/sdram_line_prefetcher.sv
// sdram_line_prefetcher: fetches one interleaved multi-channel video line per line_start
// and emits one write strobe per assembled pixel to the per-layer line FIFOs.
module sdram_line_prefetcher import gw_video_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int unsigned LINE_COUNT = DEF_LINE_COUNT,
  parameter int unsigned BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned END_BURST_LEAD = 2
) (
  input  logic clk_sys_131_072,
  input  logic reset,
  input  logic line_start,
  input  logic [9:0] line_y,
  input  logic inhibit,
  sdram_line_prefetcher_if.master mem,
  output logic fifo_clear,
  output logic pix_wr,
  output logic [(DATA_WIDTH/8)*BYTES_PER_PIXEL*8-1:0] pix_data,
  output logic busy,
  output logic line_done,
  output logic overrun
);
  localparam int unsigned CHANNELS = DATA_WIDTH / 8;
  localparam int unsigned PW = BYTES_PER_PIXEL * 8;
  localparam int unsigned WPL = words_per_line(LINE_PIXELS, BYTES_PER_PIXEL);
  localparam int unsigned WW = $clog2(WPL + 1);
  localparam int EB = int'(WPL) - int'(END_BURST_LEAD);
  prefetch_state_t state, state_d;
  logic [9:0] y_q, y_eff;
  logic [WW-1:0] words, words_d;
  logic seen, seen_d, rd_req_d, end_burst_d, line_done_d, accept;
  logic [CHANNELS-1:0] last;
  assign y_eff = 32'(y_q) >= LINE_COUNT ? '0 : y_q;
  assign mem.addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(y_eff) * ADDR_WIDTH'(WPL) + ADDR_WIDTH'(words);
  always_comb begin
    state_d = state;
    words_d = words;
    seen_d = seen;
    rd_req_d = 1'b0;
    end_burst_d = 1'b0;
    line_done_d = 1'b0;
    accept = 1'b0;
    if (line_start) begin
      state_d = REQ;
      words_d = '0;
    end else
      case (state)
        REQ: if (!inhibit) begin
          rd_req_d = 1'b1;
          seen_d = 1'b0;
          state_d = BURST;
        end
        BURST: if (mem.data_available) begin
          seen_d = 1'b1;
          if (words < WW'(WPL)) begin
            accept = 1'b1;
            words_d = words + 1'b1;
            end_burst_d = int'(words) >= EB;
          end
        end else if (seen) state_d = GAP;
        GAP: begin
          state_d = words < WW'(WPL) ? REQ : IDLE;
          line_done_d = words >= WW'(WPL);
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk_sys_131_072)
    if (reset) begin
      state <= IDLE;
      y_q <= '0;
      words <= '0;
      seen <= 1'b0;
      fifo_clear <= 1'b0;
      mem.rd_req <= 1'b0;
      mem.end_burst_req <= 1'b0;
      pix_wr <= 1'b0;
      busy <= 1'b0;
      line_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      y_q <= line_start ? line_y : y_q;
      words <= words_d;
      seen <= seen_d;
      fifo_clear <= line_start;
      mem.rd_req <= rd_req_d;
      mem.end_burst_req <= end_burst_d;
      pix_wr <= &last;
      busy <= state_d != IDLE;
      line_done <= line_done_d;
      overrun <= overrun | (line_start && state != IDLE);
    end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pixel_lane_packer #(.BYTES_PER_PIXEL(BYTES_PER_PIXEL)) u_packer (
      .clk_sys_131_072(clk_sys_131_072),
      .reset(reset),
      .lane_byte(mem.q[8*k +: 8]),
      .shift_en(accept),
      .clear(line_start),
      .pixel(pix_data[PW*k +: PW]),
      .last(last[k])
    );
  end
endmodule

// File: doc/sdram_line_prefetcher.md
Name: sdram_line_prefetcher

Overview:
- Fetches one video line of interleaved multi-layer pixel data from SDRAM via the burst controller's port, once per line start.
- Unpacks each memory word into per-channel byte lanes and assembles whole pixels per channel.
- Emits one write strobe per completed pixel to the per-layer line FIFOs.
- Generalises the fixed 720-pixel, 2-layer fetcher to any width, pixel depth and channel count, and adds re-request throttling, overrun detection and download inhibit.

Parameters:
- DATA_WIDTH, 16: memory word width; CHANNELS = DATA_WIDTH/8 is derived, lane k = bits [8k+7:8k].
- LINE_PIXELS, 720: pixels per line.
- LINE_COUNT, 720: valid lines; line_y >= LINE_COUNT fetches line 0.
- BYTES_PER_PIXEL, 3: bytes per pixel per channel.
- ADDR_WIDTH, 25: word address width.
- BASE_ADDR, 0: word address of line 0.
- END_BURST_LEAD, 2: beats of controller latency covered by the early end-burst request.

Ports:
- clk_sys_131_072  in  1  system clock
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse, already in this domain; begins fetch of line_y
- line_y  in  10  line to fetch, sampled on line_start
- inhibit  in  1  high = memory port owned by the loader; no read requests issued
- mem_addr  out  ADDR_WIDTH  word address for the read request
- mem_rd_req  out  1  one-cycle read/burst request
- mem_end_burst_req  out  1  one-cycle burst termination request
- mem_data_available  in  1  beat valid
- mem_q  in  DATA_WIDTH  beat data
- fifo_clear  out  1  one-cycle pulse, clears downstream FIFOs
- pix_wr  out  1  one-cycle pixel write strobe
- pix_data  out  CHANNELS*BYTES_PER_PIXEL*8  channel k occupies slice k; first byte received sits in the LSB
- busy  out  1  fetch in progress
- line_done  out  1  one-cycle pulse when the full line has been received
- overrun  out  1  sticky; line_start arrived before the previous line finished

Behaviour:
- WORDS_PER_LINE = LINE_PIXELS*BYTES_PER_PIXEL.
- line_addr = BASE_ADDR + y*WORDS_PER_LINE, computed at full width then truncated to ADDR_WIDTH.
- mem_addr = line_addr + words_fetched, driven combinationally from registered state.
- All outputs are registered except mem_addr.
- Reset values: every output 0, state IDLE, all counters 0.
- States and transitions:
  - IDLE: wait for line_start.
  - REQ: when inhibit is low, pulse mem_rd_req for 1 cycle and go to BURST; when inhibit is high, hold without requesting.
  - BURST: accept beats until mem_data_available falls.
  - GAP (the cycle after the fall): if words_fetched < WORDS_PER_LINE go to REQ; otherwise pulse line_done and go to IDLE.
- On line_start, in any state:
  - Latch line_y and zero words_fetched and the lane byte counters.
  - fifo_clear = 1 on the next cycle.
  - Go to REQ; the first mem_rd_req is no earlier than 1 cycle after fifo_clear.
- busy = 1 in REQ, BURST and GAP.
- Beat accept, when mem_data_available = 1 in BURST:
  - Each lane shifts its byte into the channel's shift register, entering at the top and moving toward the LSB.
  - byte_cnt increments; words_fetched increments.
  - When byte_cnt reaches BYTES_PER_PIXEL-1 on a beat: byte_cnt wraps to 0, and the next cycle carries pix_wr = 1 and pix_data = the assembled pixels.
- End burst: mem_end_burst_req pulses on the cycle after any accepted beat whose post-increment words_fetched >= WORDS_PER_LINE - END_BURST_LEAD + 1.
- Beats arriving after words_fetched == WORDS_PER_LINE: discarded, no pix_wr, counter saturated.
- Beats in IDLE or REQ: ignored. This covers trailing beats after an abort or a reset.
- line_start in REQ, BURST or GAP: abort and restart, and set overrun. overrun is cleared only by reset.
- line_start in the same cycle as a beat: line_start wins and the beat is dropped.
- Reset mid-burst: return to IDLE immediately; no end-burst is issued.
- Width rule: words_fetched is clog2(WORDS_PER_LINE+1) bits wide.

Decomposition:
- Package gw_video_pkg holds:
  - LINE_PIXELS, LINE_COUNT and BYTES_PER_PIXEL defaults;
  - a function computing WORDS_PER_LINE;
  - enum prefetch_state_t {IDLE, REQ, BURST, GAP}.
- Sub-module pixel_lane_packer (one instance per channel, generate loop): shift register plus byte count, with inputs lane_byte, shift_en, clear and output pixel.

Test Plan:
- Small config (LINE_PIXELS=4, BPP=3, words=12), one 12-beat burst of bytes 0x01..0x0C on the low lane → fifo_clear, 1 mem_rd_req at addr line_y*12, 4 pix_wr with channel 0 = 0x030201, 0x060504, …; end_burst after beat 11; line_done.
- Same config, burst split as 5 beats, gap, then 7 beats → a second mem_rd_req at addr base+5; pixel stream identical to the unsplit case.
- line_y = 800 with LINE_COUNT=720 → mem_addr = BASE_ADDR.
- line_start after beat 6 → overrun = 1, fifo_clear, new request at the new line's address; a stray beat in REQ produces no pix_wr.
- inhibit held high for 10 cycles after line_start → no mem_rd_req until the cycle after inhibit falls.
- 14 beats delivered (2 extra) → exactly 4 pix_wr; words_fetched stops at 12; reset asserted mid-burst → all outputs 0 next cycle.
